// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if
// Groups the scanned seven-segment bus and the decoded result.
//   seg     : segment pattern, active-low (0 = lit), bit6=g .. bit0=a
//   dig     : digit select, 2'b10 tens, 2'b01 ones, 2'b00 blank, 2'b11 illegal
//   out     : last successfully decoded value 0..31
//   out_val : one-cycle pulse when out is updated
//   err     : one-cycle pulse on an undecodable frame
// master drives the display bus and observes the result; slave is the decoder.
interface seg7_scan_decoder_if;
    logic [6:0] seg;
    logic [1:0] dig;
    logic [4:0] out;
    logic       out_val;
    logic       err;

    modport master (
        output seg,
        output dig,
        input  out,
        input  out_val,
        input  err
    );

    modport slave (
        input  seg,
        input  dig,
        output out,
        output out_val,
        output err
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Reconstructs a 0..31 value from a time-multiplexed, active-low two-digit
// seven-segment bus. Each (seg, dig) pair must be held STABLE samples before
// it is accepted; a tens digit is paired with the following ones digit.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : seg7_scan_decoder_if.slave (seg/dig in, out/out_val/err out)
module seg7_scan_decoder #(
    parameter int unsigned STABLE = 2  // legal 1..15
) (
    input  logic                   clk,
    input  logic                   reset,
    seg7_scan_decoder_if.slave     bus
);

    typedef enum logic [0:0] {StWaitTens, StWaitOnes} state_e;

    localparam logic [3:0] StableCnt = 4'(STABLE);

    logic [6:0] s_seg_q, s_seg_d;
    logic [1:0] s_dig_q, s_dig_d;
    logic [3:0] run_q, run_d;
    logic       hit_q, hit_d;
    state_e     state_q, state_d;
    logic [1:0] tens_q, tens_d;
    logic [4:0] out_q, out_d;
    logic       out_val_q, out_val_d;
    logic       err_q, err_d;

    logic       changed;
    logic       event_fire;
    logic       dig_valid;
    logic [3:0] dig_value;
    logic [5:0] sum;

    // Input stage and run-length counter. hit marks the single sample on
    // which the run first reaches STABLE, so a held pair fires only once.
    always_comb begin
        s_seg_d = bus.seg;
        s_dig_d = bus.dig;
        changed = (bus.seg != s_seg_q) || (bus.dig != s_dig_q);
        if (changed) begin
            run_d = 4'd1;
        end else if (run_q < StableCnt) begin
            run_d = run_q + 4'd1;
        end else begin
            run_d = run_q;
        end
        hit_d = (run_d == StableCnt) && (changed || (run_q != StableCnt));
    end

    assign event_fire = hit_q && (s_dig_q != 2'b00);

    always_comb begin
        dig_valid = 1'b1;
        dig_value = 4'd0;
        case (s_seg_q)
            7'b100_0000: dig_value = 4'd0;
            7'b111_1001: dig_value = 4'd1;
            7'b010_0100: dig_value = 4'd2;
            7'b011_0000: dig_value = 4'd3;
            7'b001_1001: dig_value = 4'd4;
            7'b001_0010: dig_value = 4'd5;
            7'b000_0010: dig_value = 4'd6;
            7'b111_1000: dig_value = 4'd7;
            7'b000_0000: dig_value = 4'd8;
            7'b001_1000: dig_value = 4'd9;
            default:     dig_valid = 1'b0;
        endcase
    end

    assign sum = ({4'd0, tens_q} * 6'd10) + {2'd0, dig_value};

    // Pairing FSM. A tens event is handled identically in both states, which
    // gives resynchronisation on a repeated tens digit for free.
    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        out_d     = out_q;
        out_val_d = 1'b0;
        err_d     = 1'b0;
        if (event_fire) begin
            unique case (s_dig_q)
                2'b10: begin
                    if (dig_valid && (dig_value <= 4'd3)) begin
                        tens_d  = dig_value[1:0];
                        state_d = StWaitOnes;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StWaitTens;
                    end
                end
                2'b01: begin
                    if (state_q == StWaitOnes) begin
                        if (dig_valid && (sum <= 6'd31)) begin
                            out_d     = sum[4:0];
                            out_val_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = StWaitTens;
                    end
                end
                2'b11: begin
                    err_d   = 1'b1;
                    state_d = StWaitTens;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_seg_q   <= 7'b111_1111;
            s_dig_q   <= 2'b00;
            run_q     <= 4'd0;
            hit_q     <= 1'b0;
            state_q   <= StWaitTens;
            tens_q    <= 2'd0;
            out_q     <= 5'd0;
            out_val_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            s_seg_q   <= s_seg_d;
            s_dig_q   <= s_dig_d;
            run_q     <= run_d;
            hit_q     <= hit_d;
            state_q   <= state_d;
            tens_q    <= tens_d;
            out_q     <= out_d;
            out_val_q <= out_val_d;
            err_q     <= err_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.out_val = out_val_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
// Directed test of seg7_scan_decoder with STABLE=2. Pulses are counted on the
// falling edge; each scenario checks the count deltas and the held value.
module tb_seg7_scan_decoder;

    localparam logic [6:0] S0 = 7'b100_0000;
    localparam logic [6:0] S1 = 7'b111_1001;
    localparam logic [6:0] S2 = 7'b010_0100;
    localparam logic [6:0] S3 = 7'b011_0000;
    localparam logic [6:0] S4 = 7'b001_1001;
    localparam logic [6:0] S5 = 7'b001_0010;
    localparam logic [6:0] S8 = 7'b000_0000;
    localparam logic [6:0] S9 = 7'b001_1000;
    localparam logic [6:0] SB = 7'b111_1111;

    localparam logic [1:0] DT = 2'b10;
    localparam logic [1:0] DO = 2'b01;
    localparam logic [1:0] DB = 2'b00;
    localparam logic [1:0] DX = 2'b11;

    logic clk;
    logic rst_n;

    int n_vec  = 0;
    int n_miss = 0;
    int n_val  = 0;
    int n_err  = 0;
    int n_both = 0;
    int val0;
    int err0;

    seg7_scan_decoder_if bus ();

    seg7_scan_decoder #(
        .STABLE (2)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.out_val) n_val++;
        if (bus.err) n_err++;
        if (bus.out_val && bus.err) n_both++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply a pair and hold it for n rising edges; returns #1 after the last.
    task automatic drive(input logic [6:0] s, input logic [1:0] d, input int n);
        bus.seg = s;
        bus.dig = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark();
        val0 = n_val;
        err0 = n_err;
    endtask

    task automatic check_frame(input string tag, input int dv, input int de,
                               input int exp_out);
        check_eq({tag, " out_val"}, n_val - val0, dv);
        check_eq({tag, " err"}, n_err - err0, de);
        check_eq({tag, " out"}, int'(bus.out), exp_out);
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.seg = SB;
        bus.dig = DB;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset out", int'(bus.out), 0);
        check_eq("reset out_val", int'(bus.out_val), 0);
        check_eq("reset err", int'(bus.err), 0);
        rst_n = 1'b1;
        drive(SB, DB, 2);

        // 1 then 5 -> 15, pulse visible only after the third edge
        mark();
        drive(S1, DT, 3);
        drive(S5, DO, 2);
        @(negedge clk);
        check_eq("lat15 early", int'(bus.out_val), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("lat15 pulse", int'(bus.out_val), 1);
        check_eq("lat15 out", int'(bus.out), 15);
        @(posedge clk);
        #1;
        drive(SB, DB, 3);
        check_frame("v15", 1, 0, 15);

        // 3 then 2 -> 32 out of range
        mark();
        drive(S3, DT, 3);
        drive(S2, DO, 3);
        drive(SB, DB, 3);
        check_frame("v32", 0, 1, 15);

        // Short tens glitch, stray ones ignored
        mark();
        drive(S1, DT, 1);
        drive(SB, DB, 2);
        drive(S4, DO, 3);
        drive(SB, DB, 3);
        check_frame("glitch", 0, 0, 15);

        mark();
        drive(S2, DT, 3);
        drive(S8, DO, 3);
        drive(SB, DB, 3);
        check_frame("v28", 1, 0, 28);

        // Undecodable tens pattern
        mark();
        drive(SB, DT, 3);
        drive(SB, DB, 3);
        check_frame("bad tens", 0, 1, 28);

        // Illegal select after a good tens drops it; following ones ignored
        mark();
        drive(S1, DT, 3);
        drive(S0, DX, 3);
        drive(S0, DO, 3);
        drive(SB, DB, 3);
        check_frame("illegal sel", 0, 1, 28);

        // Resync on second tens, then ones held long -> one pulse
        mark();
        drive(S1, DT, 3);
        drive(S3, DT, 3);
        drive(S0, DO, 20);
        drive(SB, DB, 3);
        check_frame("resync30", 1, 0, 30);

        // Reset mid-ones discards the stored tens
        mark();
        drive(S2, DT, 3);
        drive(S9, DO, 1);
        rst_n = 1'b0;
        #1;
        check_eq("async reset out", int'(bus.out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(S9, DO, 4);
        drive(SB, DB, 3);
        check_frame("reset mid", 0, 0, 0);

        check_eq("val err overlap", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side companion to the two-digit seven-segment display encoder: it watches a time-multiplexed, active-low seven-segment bus (one shared segment pattern plus a digit select) and reconstructs the 5-bit binary value 0–31 being displayed. It sits at the board/test-fixture boundary. It filters scan glitches by requiring each digit to be stable for a configurable number of cycles, pairs a tens digit with the following ones digit, and emits the value with a one-cycle valid pulse, or an error pulse for undecodable frames.

## Interface
- STABLE, default 2: number of consecutive identical samples (seg, dig) required to accept a digit; legal range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-low; clears all state immediately.
- seg  in  7  segment pattern, active-low (0 = lit); bit6=g … bit0=a.
- dig  in  2  digit select: 2'b10 = tens, 2'b01 = ones, 2'b00 = blank, 2'b11 = illegal.
- out  out  5  last successfully decoded value; holds until the next good frame.
- out_val  out  1  one-cycle pulse when `out` is updated.
- err  out  1  one-cycle pulse on an invalid digit, illegal select, or value > 31.

## Operation
- Digit table (seg → digit):
  - 100_0000 → 0; 111_1001 → 1; 010_0100 → 2; 011_0000 → 3; 001_1001 → 4
  - 001_0010 → 5; 000_0010 → 6; 111_1000 → 7; 000_0000 → 8; 001_1000 → 9
  - Any other pattern is invalid.
- Input stage: `seg`/`dig` are registered every cycle into `s_seg`/`s_dig`.
- Run counter `run` (4 bits):
  - Set to 1 when the new sample differs from the held one.
  - Otherwise increments, saturating at STABLE.
- Accept event: fires on the cycle `run` first reaches STABLE, with `s_dig` != 00. It fires at most once per stable run, so holding a digit indefinitely produces one event. Blank runs never produce events.
- FSM states: WAIT_TENS, WAIT_ONES. Register `tens` is 2 bits.
  - WAIT_TENS, tens event:
    - Valid digit ≤ 3 → store `tens`, go to WAIT_ONES.
    - Invalid digit or digit > 3 → `err`, stay.
  - WAIT_TENS, ones event: ignored (frame alignment), no `err`.
  - WAIT_ONES, ones event:
    - Valid digit, v = tens*10 + ones ≤ 31 → `out`=v, `out_val`, go to WAIT_TENS.
    - v > 31 or invalid digit → `err`, go to WAIT_TENS, `out` unchanged.
  - WAIT_ONES, tens event: resynchronise. Treat it exactly as a tens event in WAIT_TENS, with no `err` for the discarded tens.
  - Any state, event with `s_dig`=11 → `err`, go to WAIT_TENS.
- Arithmetic: tens*10 + ones is computed at 6 bits, compared against 31, and the low 5 bits are stored.
- `out_val` and `err` are never high in the same cycle.

## Timing
- Reset values:
  - `out`=0, `out_val`=0, `err`=0, FSM=WAIT_TENS, `tens`=0.
  - `s_seg`=111_1111, `s_dig`=00, `run`=0.
- Reset is asynchronous on assertion; the first update happens on the first rising edge after deassertion.
- Latency: inputs applied after edge 0 and held → captured at edge 1 (`run`=1) → event when `run`=STABLE at edge STABLE → `out_val`/`err` registered high after edge STABLE+1 for exactly one cycle.
- Glitch rule: a (seg, dig) pair held for fewer than STABLE samples has no effect on FSM, `out`, or flags.
- STABLE=1: every change to a new non-blank pair is an event; the same pair held continuously fires once.
- Back-to-back: a change directly from a tens pair to a ones pair, with no blank between, is legal. The ones event follows STABLE samples later.
- Reset mid-frame discards a stored `tens`. A ones digit after reset is ignored.

## Test plan
All scenarios use STABLE=2; each digit is held 3 cycles unless stated.
- Reset, then tens=111_1001, ones=001_0010 → `out`=15 with one `out_val` pulse 3 edges after ones applied; `err` stays 0.
- Tens=011_0000, ones=010_0100 (32) → one `err` pulse, no `out_val`, `out` stays 15.
- Tens=1 held 1 cycle, then blank, then ones=4 → no event for tens, ones ignored, no flags; then tens=2, ones=8 → `out`=28.
- dig=10 with seg=111_1111 → `err`; dig=11 with any seg → `err`, FSM back to WAIT_TENS; ones=0 next → ignored.
- Resync and hold: tens=1, tens=3, ones=0 → `out`=30. Ones then held 20 cycles → exactly one `out_val`.
- Tens=2 accepted, then `reset` low for 1 cycle mid-ones-digit, then ones=9 → no `out_val`, `out`=0.
